// File: rtl/div_issue_sched.sv
// Issue/writeback scheduler for the pipelined divider: tracks divides in an
// DIV_LAT-slot tag pipe, stalls decode on hazards, and owns the divide writeback port.
// Latency: a divide issued in cycle t writes back (wb_div_valid) in cycle t+DIV_LAT.
// Backpressure: stall_d holds decode; in-flight divides never stall and are never squashed.
// Build option: define DIV_SCHED_BYPASS_EN to forward completing results instead of stalling.
module div_issue_sched #(
  parameter int DIV_LAT         = 8,
  parameter int WB_OFFSET       = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic        d_is_div,
  input  logic        d_div_get_rem,
  input  logic        d_reg_we,
  input  logic [4:0]  d_rd,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_uses_rs1,
  input  logic        d_uses_rs2,
  input  logic        flush,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        stall_d,
  output logic        issue,
  output logic        wb_div_valid,
  output logic [4:0]  wb_div_rd,
  output logic [31:0] wb_div_data,
  output logic [31:0] busy_mask,
  output logic [4:0]  outstanding
`ifdef DIV_SCHED_BYPASS_EN
  ,
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_data
`endif
);

  // Last slot is the completing divide; the port slot is the divide that will
  // write back in the same cycle as a normal op issued now.
  localparam int         LAST      = DIV_LAT - 1;
  localparam int         PORT_SLOT = DIV_LAT - WB_OFFSET - 1;
  localparam logic [4:0] MAX_OUT   = 5'(MAX_OUTSTANDING);

  logic [DIV_LAT-1:0] r_vld;
  logic [DIV_LAT-1:0] r_rem;
  logic [4:0]         r_rd [DIV_LAT];
  logic [4:0]         r_outstanding;

  logic        w_load_vld;
  logic        w_done;
  logic [31:0] w_busy_all;
  logic [31:0] w_raw_mask;
  logic        w_raw;
  logic        w_waw;
  logic        w_port;
  logic        w_cap;

  // Only tracked divides (non-zero rd) enter the tag pipe as valid.
  assign w_load_vld = issue & d_is_div & (d_rd != 5'd0);
  assign w_done     = r_vld[LAST];

  // Build the pending-destination masks; with bypass the completing slot is
  // excluded from the RAW mask because its result is forwarded instead.
  always_comb begin
    w_busy_all = '0;
    w_raw_mask = '0;
    for (int k = 0; k < DIV_LAT; k++) begin
      if (r_vld[k]) begin
        w_busy_all[r_rd[k]] = 1'b1;
`ifdef DIV_SCHED_BYPASS_EN
        if (k != LAST) w_raw_mask[r_rd[k]] = 1'b1;
`else
        w_raw_mask[r_rd[k]] = 1'b1;
`endif
      end
    end
    w_busy_all[0] = 1'b0;
    w_raw_mask[0] = 1'b0;
  end

  assign w_raw  = (d_uses_rs1 & (d_rs1 != 5'd0) & w_raw_mask[d_rs1]) |
                  (d_uses_rs2 & (d_rs2 != 5'd0) & w_raw_mask[d_rs2]);
  // Divide-after-divide to the same rd is safe: divides retire in order.
  assign w_waw  = d_reg_we & ~d_is_div & w_busy_all[d_rd];
  assign w_port = d_reg_we & ~d_is_div & r_vld[PORT_SLOT];
  // A completing divide frees a slot this cycle, so a full tracker can still issue.
  assign w_cap  = d_is_div & (r_outstanding == MAX_OUT) & ~w_done;

  assign stall_d = d_valid & (w_raw | w_waw | w_port | w_cap);
  assign issue   = d_valid & ~stall_d & ~flush;

  assign wb_div_valid = w_done;
  assign wb_div_rd    = w_done ? r_rd[LAST] : 5'd0;
  assign wb_div_data  = r_rem[LAST] ? div_remainder : div_quotient;
  assign busy_mask    = w_busy_all;
  assign outstanding  = r_outstanding;

`ifdef DIV_SCHED_BYPASS_EN
  assign fwd_rs1_hit = d_valid & d_uses_rs1 & (d_rs1 != 5'd0) & w_done &
                       (r_rd[LAST] == d_rs1) & ~w_raw_mask[d_rs1];
  assign fwd_rs2_hit = d_valid & d_uses_rs2 & (d_rs2 != 5'd0) & w_done &
                       (r_rd[LAST] == d_rs2) & ~w_raw_mask[d_rs2];
  assign fwd_data    = wb_div_data;
`endif

  // Advance the tag pipe one slot per cycle and keep the in-flight count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld         <= '0;
      r_rem         <= '0;
      r_outstanding <= '0;
      for (int k = 0; k < DIV_LAT; k++) r_rd[k] <= '0;
    end else begin
      r_vld <= {r_vld[DIV_LAT-2:0], w_load_vld};
      r_rem <= {r_rem[DIV_LAT-2:0], d_div_get_rem & w_load_vld};
      r_rd[0] <= w_load_vld ? d_rd : 5'd0;
      for (int k = 1; k < DIV_LAT; k++) r_rd[k] <= r_rd[k-1];
      case ({w_load_vld, w_done})
        2'b10:   r_outstanding <= r_outstanding + 5'd1;
        2'b01:   r_outstanding <= r_outstanding - 5'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
